// File: rtl/regfile_2r1w.sv
// regfile_2r1w: DEPTH x DATA_W register file with one write port, two
// registered read ports with write-first forwarding, and a sequenced clear
// engine that zeroes one entry per cycle.
// Optional build macro REGFILE_ZERO_REG_EN: register 0 is hardwired to zero.
module regfile_2r1w #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid,
    input  logic              clr_req,
    output logic              busy,
    output logic [DEPTH-1:0]  written
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // One extra bit so DEPTH itself is representable for range checks.
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   regs_q [DEPTH];
    logic [DATA_W-1:0]   regs_d [DEPTH];
    logic [DEPTH-1:0]    written_q, written_d;
    logic [DATA_W-1:0]   rd_data_a_q, rd_data_a_d;
    logic [DATA_W-1:0]   rd_data_b_q, rd_data_b_d;
    logic                rd_valid_q, rd_valid_d;
    logic                busy_q, busy_d;
    logic                wr_acc_s;
    logic                clr_act_s;

    // Value a read port captures: out-of-range reads give zero, then the
    // accepted write wins, then the entry being cleared reads as zero.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic              wr_hit_en,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata,
        input logic              clr_en,
        input logic [ADDR_W-1:0] cptr,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] val;
        if ({1'b0, addr} >= DEPTH_C) begin
            val = {DATA_W{1'b0}};
        end else if (wr_hit_en && (addr == waddr)) begin
            val = wdata;
        end else if (clr_en && (addr == cptr)) begin
            val = {DATA_W{1'b0}};
        end else begin
            val = stored;
        end
        return val;
    endfunction

    assign clr_act_s = (state_q == ST_CLEAR);

    // Write acceptance: only in IDLE, only for in-range addresses.
    always_comb begin
        wr_acc_s = 1'b0;
        if ((state_q == ST_IDLE) && wr_en && ({1'b0, wr_addr} < DEPTH_C)) begin
`ifdef REGFILE_ZERO_REG_EN
            wr_acc_s = (wr_addr != ADDR_W'(0));
`else
            wr_acc_s = 1'b1;
`endif
        end else begin
            wr_acc_s = 1'b0;
        end
    end

    // Clear-engine next state, pointer sequencing and busy flag.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = {ADDR_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (ptr_q == LAST_C) begin
                    state_d = ST_IDLE;
                    ptr_d   = {ADDR_W{1'b0}};
                end else begin
                    ptr_d   = ptr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = {ADDR_W{1'b0}};
            end
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    // Storage and written-mask updates from the write port and clear engine.
    always_comb begin
        regs_d    = regs_q;
        written_d = written_q;
        if (wr_acc_s) begin
            regs_d[wr_addr]    = wr_data;
            written_d[wr_addr] = 1'b1;
        end else begin
            written_d = written_q;
        end
        if (clr_act_s) begin
            regs_d[ptr_q]    = {DATA_W{1'b0}};
            written_d[ptr_q] = 1'b0;
        end else begin
            written_d = written_d;
        end
    end

    // Read ports: capture on rd_en, otherwise hold the previous data.
    always_comb begin
        rd_data_a_d = rd_data_a_q;
        rd_data_b_d = rd_data_b_q;
        rd_valid_d  = rd_en;
        if (rd_en) begin
            rd_data_a_d = read_port(rd_addr_a, wr_acc_s, wr_addr, wr_data,
                                    clr_act_s, ptr_q, regs_q[rd_addr_a]);
            rd_data_b_d = read_port(rd_addr_b, wr_acc_s, wr_addr, wr_data,
                                    clr_act_s, ptr_q, regs_q[rd_addr_b]);
        end else begin
            rd_valid_d  = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= {ADDR_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
            written_q   <= {DEPTH{1'b0}};
            rd_data_a_q <= {DATA_W{1'b0}};
            rd_data_b_q <= {DATA_W{1'b0}};
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            regs_q      <= regs_d;
            written_q   <= written_d;
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
            rd_valid_q  <= rd_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;
    assign rd_valid  = rd_valid_q;
    assign busy      = busy_q;
    assign written   = written_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: directed walk through the main scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_regfile_2r1w;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             rd_en;
    logic [AW-1:0]    rd_addr_a;
    logic [AW-1:0]    rd_addr_b;
    logic [DW-1:0]    rd_data_a;
    logic [DW-1:0]    rd_data_b;
    logic             rd_valid;
    logic             clr_req;
    logic             busy;
    logic [DEPTH-1:0] written;

    regfile_2r1w #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .rd_valid  (rd_valid),
        .clr_req   (clr_req),
        .busy      (busy),
        .written   (written)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Behavioural model: memory contents, written set, and clear progress
    // expressed as "clear running, next index to zero".
    logic [DW-1:0]    m_mem [DEPTH];
    logic [DEPTH-1:0] m_written;
    bit               m_clr_on;
    int               m_clr_idx;
    logic [DW-1:0]    e_rd_a, e_rd_b;
    logic             e_valid, e_busy;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] m_read(input int addr, input bit wacc,
                                             input int waddr, input logic [DW-1:0] wdata);
        if (addr >= DEPTH) return 8'h00;
        if (wacc && addr == waddr) return wdata;
        if (m_clr_on && addr == m_clr_idx) return 8'h00;
        return m_mem[addr];
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        bit wacc;
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
            m_written = '0;
            m_clr_on  = 1'b0;
            m_clr_idx = 0;
            e_rd_a    = 8'h00;
            e_rd_b    = 8'h00;
            e_valid   = 1'b0;
        end else begin
            wacc = !m_clr_on && wr_en && (int'(wr_addr) < DEPTH) &&
                   !(ZERO_REG && wr_addr == 2'd0);
            if (rd_en) begin
                e_rd_a = m_read(int'(rd_addr_a), wacc, int'(wr_addr), wr_data);
                e_rd_b = m_read(int'(rd_addr_b), wacc, int'(wr_addr), wr_data);
            end
            e_valid = rd_en;
            if (wacc) begin
                m_mem[wr_addr]     = wr_data;
                m_written[wr_addr] = 1'b1;
            end
            if (m_clr_on) begin
                m_mem[m_clr_idx]     = 8'h00;
                m_written[m_clr_idx] = 1'b0;
                m_clr_idx++;
                if (m_clr_idx == DEPTH) begin
                    m_clr_on  = 1'b0;
                    m_clr_idx = 0;
                end
            end else if (clr_req) begin
                m_clr_on  = 1'b1;
                m_clr_idx = 0;
            end
        end
        e_busy = m_clr_on;
    endtask

    // Drive one cycle of inputs, update the model, and return just after the edge.
    task automatic step(input logic rn, input logic we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                        input logic [AW-1:0] rb, input logic cr);
        @(negedge clk);
        #1;
        rst_n = rn; wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr_a = ra; rd_addr_b = rb; clr_req = cr;
        model_edge();
        @(posedge clk);
        #2;
    endtask

    // Compare process: DUT outputs against the model on every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("rd_data_a", 32'(rd_data_a), 32'(e_rd_a));
            check("rd_data_b", 32'(rd_data_b), 32'(e_rd_b));
            check("rd_valid",  32'(rd_valid),  32'(e_valid));
            check("busy",      32'(busy),      32'(e_busy));
            check("written",   32'(written),   32'(m_written));
        end
    end

    initial begin
        clk = 1'b0;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'h00;
        rd_en = 1'b0; rd_addr_a = 2'd0; rd_addr_b = 2'd0; clr_req = 1'b0;

        // 1: reset then read A=0, B=3
        step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0);
        chk_en = 1'b1;
        step(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd3, 1'b0);
        check("t1_rd_a", 32'(rd_data_a), 32'h00);
        check("t1_rd_b", 32'(rd_data_b), 32'h00);
        check("t1_valid", 32'(rd_valid), 32'h1);
        check("t1_written", 32'(written), 32'h0);
        check("t1_busy", 32'(busy), 32'h0);

        // 2: two writes, read back, then hold
        step(1'b1, 1'b1, 2'd1, 8'hA5, 1'b0, 2'd0, 2'd0, 1'b0);
        step(1'b1, 1'b1, 2'd2, 8'h3C, 1'b0, 2'd0, 2'd0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd2, 1'b0);
        check("t2_rd_a", 32'(rd_data_a), 32'hA5);
        check("t2_rd_b", 32'(rd_data_b), 32'h3C);
        check("t2_written", 32'(written), 32'h6);
        step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd3, 2'd3, 1'b0);
        check("t2_hold_a", 32'(rd_data_a), 32'hA5);
        check("t2_hold_b", 32'(rd_data_b), 32'h3C);
        check("t2_hold_valid", 32'(rd_valid), 32'h0);

        // 3: write-first forwarding on both ports
        step(1'b1, 1'b1, 2'd3, 8'h11, 1'b0, 2'd0, 2'd0, 1'b0);
        step(1'b1, 1'b1, 2'd3, 8'h7E, 1'b1, 2'd3, 2'd3, 1'b0);
        check("t3_fwd_a", 32'(rd_data_a), 32'h7E);
        check("t3_fwd_b", 32'(rd_data_b), 32'h7E);

        // 4: fill, clear with concurrent write, lost write during clear
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b1, AW'(i), DW'(8'h11 * (i + 1)), 1'b0, 2'd0, 2'd0, 1'b0);
        step(1'b1, 1'b1, 2'd0, 8'h99, 1'b0, 2'd0, 2'd0, 1'b1);
        check("t4_busy0", 32'(busy), 32'h1);
        step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0);
        check("t4_busy1", 32'(busy), 32'h1);
        step(1'b1, 1'b1, 2'd2, 8'h55, 1'b0, 2'd0, 2'd0, 1'b0);
        check("t4_busy2", 32'(busy), 32'h1);
        step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0);
        check("t4_busy3", 32'(busy), 32'h1);
        step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0);
        check("t4_busy_end", 32'(busy), 32'h0);
        step(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd1, 1'b0);
        check("t4_rd_0", 32'(rd_data_a), 32'h00);
        check("t4_rd_1", 32'(rd_data_b), 32'h00);
        step(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd3, 1'b0);
        check("t4_rd_2", 32'(rd_data_a), 32'h00);
        check("t4_rd_3", 32'(rd_data_b), 32'h00);
        check("t4_written", 32'(written), 32'h0);

        // 5: reset in the 2nd clear cycle, then normal operation
        step(1'b1, 1'b1, 2'd3, 8'h44, 1'b0, 2'd0, 2'd0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd3, 1'b1);
        step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0);
        step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0);
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_rd_a", 32'(rd_data_a), 32'h00);
        check("t5_rd_b", 32'(rd_data_b), 32'h00);
        check("t5_valid", 32'(rd_valid), 32'h0);
        check("t5_written", 32'(written), 32'h0);
        step(1'b1, 1'b1, 2'd1, 8'hF0, 1'b1, 2'd1, 2'd0, 1'b0);
        check("t5_fwd", 32'(rd_data_a), 32'hF0);
        check("t5_written_after", 32'(written), 32'h2);
        step(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd1, 1'b0);
        check("t5_rd", 32'(rd_data_b), 32'hF0);

        // 6: register 0 behaviour
        step(1'b1, 1'b1, 2'd0, 8'hFF, 1'b1, 2'd0, 2'd1, 1'b0);
        check("t6_rd0", 32'(rd_data_a), ZERO_REG ? 32'h00 : 32'hFF);
        check("t6_written0", 32'(written[0]), ZERO_REG ? 32'h0 : 32'h1);

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            step(($urandom_range(0, 99) != 0),
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), DW'($urandom),
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                 AW'($urandom_range(0, DEPTH - 1)), ($urandom_range(0, 19) == 0));
        end

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
